// File: rtl/char_buffer_ctrl_if.sv
// Writer command channel and display read channel of the character buffer.
interface char_buffer_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_cmd;
  logic [2:0] wr_code;
  logic [4:0] rd_row;
  logic [6:0] rd_col;
  logic [2:0] rd_code;

  // Master drives commands and the display scan position.
  modport master (
    output wr_valid, wr_cmd, wr_code, rd_row, rd_col,
    input  wr_ready, rd_code
  );

  // Slave is the buffer controller.
  modport slave (
    input  wr_valid, wr_cmd, wr_code, rd_row, rd_col,
    output wr_ready, rd_code
  );
endinterface

// File: rtl/char_buffer_ctrl.sv
// Text-mode character buffer: a ROWS x COLS array of 3-bit codes written
// through a cursor-based command port and read by the display scan with a
// one-cycle registered output. Reset (and the clear command) wipes the
// whole array one cell per cycle before commands are accepted.
module char_buffer_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [2:0] BLANK = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  char_buffer_ctrl_if.slave   bus,
  output logic [4:0]          cur_row,
  output logic [6:0]          cur_col,
  output logic                busy
);

  localparam int          CELLS  = ROWS * COLS;
  localparam logic [11:0] LAST   = 12'(CELLS - 1);
  localparam logic [11:0] COLS12 = 12'(COLS);

  localparam logic [1:0] CMD_PUT   = 2'b00;
  localparam logic [1:0] CMD_NL    = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_clr_idx;
  logic [4:0]  r_cur_row;
  logic [6:0]  r_cur_col;
  logic [2:0]  r_mem [CELLS];
  logic [2:0]  r_rd_code_p1;

  logic        w_accept;
  logic        w_put;
  logic [11:0] w_wr_addr;
  logic        w_rd_inrange;
  logic [11:0] w_rd_addr;

  // Row advance with wrap to the top; the screen never scrolls.
  function automatic logic [4:0] f_next_row(input logic [4:0] row);
    return (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
  endfunction

  assign w_accept  = bus.wr_valid && (r_state == S_IDLE);
  assign w_put     = w_accept && (bus.wr_cmd == CMD_PUT);
  assign w_wr_addr = {7'b0, r_cur_row} * COLS12 + {5'b0, r_cur_col};

  assign w_rd_inrange = ({1'b0, bus.rd_row} < 6'(ROWS)) && ({1'b0, bus.rd_col} < 8'(COLS));
  assign w_rd_addr    = w_rd_inrange ? ({7'b0, bus.rd_row} * COLS12 + {5'b0, bus.rd_col}) : 12'd0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_CLEAR;
    else        r_state <= w_next_state;
  end

  // Next state: leave CLEAR after the last cell, re-enter on a clear command.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_idx == LAST) w_next_state = S_IDLE;
      S_IDLE:  if (w_accept && (bus.wr_cmd == CMD_CLEAR)) w_next_state = S_CLEAR;
      default: w_next_state = S_CLEAR;
    endcase
  end

  // Handshake and status decoded straight from the state.
  always_comb begin
    bus.wr_ready = (r_state == S_IDLE);
    busy         = (r_state == S_CLEAR);
  end

  // Clear sweep index: steps through every cell while clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_idx <= 12'd0;
    end else if (r_state == S_CLEAR) begin
      if (r_clr_idx != LAST) r_clr_idx <= r_clr_idx + 12'd1;
    end else if (w_accept && (bus.wr_cmd == CMD_CLEAR)) begin
      r_clr_idx <= 12'd0;
    end
  end

  // Cursor update on each accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_row <= 5'd0;
      r_cur_col <= 7'd0;
    end else if (w_accept) begin
      case (bus.wr_cmd)
        CMD_PUT: begin
          if (r_cur_col == 7'(COLS - 1)) begin
            r_cur_col <= 7'd0;
            r_cur_row <= f_next_row(r_cur_row);
          end else begin
            r_cur_col <= r_cur_col + 7'd1;
          end
        end
        CMD_NL: begin
          r_cur_col <= 7'd0;
          r_cur_row <= f_next_row(r_cur_row);
        end
        default: begin
          r_cur_row <= 5'd0;
          r_cur_col <= 7'd0;
        end
      endcase
    end
  end

  // Cell storage: blanking sweep while clearing, character writes when idle.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)
      r_mem[r_clr_idx] <= BLANK;
    else if (w_put)
      r_mem[w_wr_addr] <= bus.wr_code;
  end

  // ---- read stage p1: registered code, blank when off-screen or clearing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_rd_code_p1 <= BLANK;
    else if ((r_state == S_CLEAR) || !w_rd_inrange)
      r_rd_code_p1 <= BLANK;
    else
      r_rd_code_p1 <= r_mem[w_rd_addr];
  end

  assign bus.rd_code = r_rd_code_p1;
  assign cur_row     = r_cur_row;
  assign cur_col     = r_cur_col;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Bench for char_buffer_ctrl: a screen-level model (cursor as row/col with
// modular wrap, memory as a flat cell array, clear as a cycle countdown) is
// compared against the DUT on every falling edge, alongside directed
// scenarios with hand-computed expectations.
module tb_char_buffer_ctrl;

  localparam int ROWS  = 30;
  localparam int COLS  = 80;
  localparam int CELLS = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  char_buffer_ctrl_if bus ();

  char_buffer_ctrl dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bus),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mem [CELLS];
  int m_clear_left = CELLS;
  int m_row = 0;
  int m_col = 0;
  int m_rd  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear_left = CELLS;
        m_row = 0;
        m_col = 0;
        m_rd  = 0;
      end else begin
        if (m_clear_left > 0 || int'(bus.rd_row) >= ROWS || int'(bus.rd_col) >= COLS)
          m_rd = 0;
        else
          m_rd = m_mem[int'(bus.rd_row) * COLS + int'(bus.rd_col)];
        if (m_clear_left > 0) begin
          m_clear_left--;
          if (m_clear_left == 0)
            for (int i = 0; i < CELLS; i++) m_mem[i] = 0;
        end else if (bus.wr_valid) begin
          case (bus.wr_cmd)
            2'b00: begin
              m_mem[m_row * COLS + m_col] = int'(bus.wr_code);
              m_col++;
              if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
              end
            end
            2'b01: begin
              m_col = 0;
              m_row = (m_row + 1) % ROWS;
            end
            2'b10: begin
              m_row = 0;
              m_col = 0;
              m_clear_left = CELLS;
            end
            default: begin
              m_row = 0;
              m_col = 0;
            end
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy",     int'(busy),         (m_clear_left > 0) ? 1 : 0);
        chk("wr_ready", int'(bus.wr_ready), (m_clear_left > 0) ? 0 : 1);
        chk("cur_row",  int'(cur_row),      m_row);
        chk("cur_col",  int'(cur_col),      m_col);
        chk("rd_code",  int'(bus.rd_code),  m_rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.wr_ready && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.wr_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [2:0] code);
    int c;
    wait_ready(c);
    bus.wr_valid = 1'b1;
    bus.wr_cmd   = cmd;
    bus.wr_code  = code;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_lit(input string name, input int r, input int c, input int exp);
    bus.rd_row = 5'(r);
    bus.rd_col = 7'(c);
    @(negedge clk);
    chk(name, int'(bus.rd_code), exp);
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        bus.rd_row = 5'(r);
        bus.rd_col = 7'(c);
        @(negedge clk);
      end
  endtask

  task automatic chk_cursor(input string name, input int r, input int c);
    chk({name, "_row"}, int'(cur_row), r);
    chk({name, "_col"}, int'(cur_col), c);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    bus.wr_valid = 1'b0;
    bus.wr_cmd   = 2'b00;
    bus.wr_code  = 3'd0;
    bus.rd_row   = 5'd0;
    bus.rd_col   = 7'd0;

    // Reset state and power-up clear length.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(bus.wr_ready), 0);
    chk_cursor("rst_cur", 0, 0);
    rst_n = 1'b1;
    wait_ready(n);
    chk("powerup_clear_cycles", n, 2400);
    chk("powerup_busy_done", int'(busy), 0);
    sweep();

    // Codes 1..7 along row 0.
    for (int k = 1; k <= 7; k++) send(2'b00, 3'(k));
    chk_cursor("after7", 0, 7);
    rd_lit("rd_0_3", 0, 3, 4);
    rd_lit("rd_0_6", 0, 6, 7);

    // Wrap from the bottom-right corner by a character.
    send(2'b01, 3'd0);
    chk_cursor("nl_row1", 1, 0);
    for (int k = 0; k < 28; k++) send(2'b01, 3'd0);
    chk_cursor("at_row29", 29, 0);
    for (int k = 0; k < 79; k++) send(2'b00, 3'(k % 8));
    chk_cursor("at_29_79", 29, 79);
    send(2'b00, 3'd2);
    chk_cursor("char_wrap", 0, 0);
    rd_lit("rd_29_79", 29, 79, 2);

    // Wrap by newline from (29,5).
    send(2'b11, 3'd0);
    for (int k = 0; k < 29; k++) send(2'b01, 3'd0);
    for (int k = 0; k < 5; k++) send(2'b00, 3'd1);
    chk_cursor("at_29_5", 29, 5);
    send(2'b01, 3'd0);
    chk_cursor("nl_wrap", 0, 0);

    // Off-screen reads return blank even where row 0 holds data.
    rd_lit("rd_row30", 30, 3, 0);
    rd_lit("rd_col80", 0, 80, 0);
    rd_lit("rd_col127", 0, 127, 0);
    rd_lit("rd_0_1_pin", 0, 1, 2);

    // Same-cycle read and write of (2,2): old 3 first, then 5.
    send(2'b11, 3'd0);
    send(2'b01, 3'd0);
    send(2'b01, 3'd0);
    send(2'b00, 3'd0);
    send(2'b00, 3'd0);
    send(2'b00, 3'd3);
    send(2'b11, 3'd0);
    send(2'b01, 3'd0);
    send(2'b01, 3'd0);
    send(2'b00, 3'd0);
    send(2'b00, 3'd0);
    bus.rd_row   = 5'd2;
    bus.rd_col   = 7'd2;
    bus.wr_valid = 1'b1;
    bus.wr_cmd   = 2'b00;
    bus.wr_code  = 3'd5;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("rw_same_old", int'(bus.rd_code), 3);
    @(negedge clk);
    chk("rw_same_new", int'(bus.rd_code), 5);

    // Clear with valid held high; the next command waits for ready.
    bus.wr_valid = 1'b1;
    bus.wr_cmd   = 2'b10;
    @(negedge clk);
    bus.wr_cmd   = 2'b00;
    bus.wr_code  = 3'd6;
    chk_cursor("clr_cur", 0, 0);
    wait_ready(n);
    chk("clear_cmd_cycles", n, 2400);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk_cursor("after_clear_put", 0, 1);
    rd_lit("clr_0_0", 0, 0, 6);
    rd_lit("clr_0_3", 0, 3, 0);
    rd_lit("clr_2_2", 2, 2, 0);
    sweep();

    // Reset in the middle of normal operation.
    send(2'b00, 3'd7);
    send(2'b01, 3'd0);
    rd_lit("pre_rst_rd", 0, 1, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", int'(busy), 1);
    chk("midop_rst_ready", int'(bus.wr_ready), 0);
    chk_cursor("midop_rst_cur", 0, 0);
    chk("midop_rst_rd", int'(bus.rd_code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("midop_reclear_cycles", n, 2400);

    // Reset at clear index 1000 restarts the full sweep.
    send(2'b00, 3'd4);
    send(2'b10, 3'd0);
    repeat (1000) @(negedge clk);
    chk("mid_clear_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_rst_busy", int'(busy), 1);
    chk("midclr_rst_ready", int'(bus.wr_ready), 0);
    chk_cursor("midclr_rst_cur", 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("midclr_reclear_cycles", n, 2400);
    rd_lit("final_0_0", 0, 0, 0);
    rd_lit("final_0_1", 0, 1, 0);
    chk_cursor("final_cur", 0, 0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/char_buffer_ctrl.md
CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per text row (pix_x[9:3] range).
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per frame (pix_y[8:4] range).
REQ-003 SHALL have parameter BLANK, default 3'b000, meaning the character code for an empty cell.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port wr_valid  input  1  writer presents a command.
REQ-007 SHALL have port wr_ready  output  1  block accepts a command this cycle.
REQ-008 SHALL have port wr_cmd  input  2  00 = put char, 01 = newline, 10 = clear screen, 11 = home.
REQ-009 SHALL have port wr_code  input  3  character code for put char; ignored for other commands.
REQ-010 SHALL have port rd_row  input  5  text row being displayed (pix_y[8:4]).
REQ-011 SHALL have port rd_col  input  7  text column being displayed (pix_x[9:3]).
REQ-012 SHALL have port rd_code  output  3  registered character code at (rd_row, rd_col), feeding the font ROM address.
REQ-013 SHALL have port cur_row  output  5  current cursor row.
REQ-014 SHALL have port cur_col  output  7  current cursor column.
REQ-015 SHALL have port busy  output  1  high while a screen clear is in progress.

Function
REQ-016 SHALL store ROWS*COLS 3-bit cells addressed linearly as row*COLS+col, using a 12-bit index (0..2399 at default).
REQ-017 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-018 SHALL, in CLEAR, write BLANK to one cell per cycle at an internal clear index from 0 to ROWS*COLS-1, then enter IDLE on the cycle after writing the last cell (ROWS*COLS cycles total).
REQ-019 SHALL drive wr_ready = 1 only in IDLE, and busy = 1 only in CLEAR (combinational from state).
REQ-020 SHALL accept a command exactly on a cycle where wr_valid and wr_ready are both 1; a command with wr_ready = 0 is not consumed, and the writer holds it.
REQ-021 SHALL, on accepted put char, write wr_code to cell (cur_row, cur_col) and advance the cursor one column.
REQ-022 SHALL, on cursor advance from cur_col = COLS-1, set cur_col to 0 and increment cur_row.
REQ-023 SHALL, on row increment from cur_row = ROWS-1, wrap cur_row to 0 with no scrolling; old contents remain until overwritten.
REQ-024 SHALL, on accepted newline, set cur_col to 0 and increment cur_row with the wrap of REQ-023; memory unchanged.
REQ-025 SHALL, on accepted clear screen, set the cursor to (0,0), reset the clear index to 0 and enter CLEAR on the next cycle.
REQ-026 SHALL, on accepted home, set the cursor to (0,0) without modifying memory.
REQ-027 SHALL update rd_code one clock after rd_row/rd_col are sampled (latency 1 cycle).
REQ-028 SHALL return BLANK on rd_code when the sampled rd_row >= ROWS or rd_col >= COLS.
REQ-029 SHALL return BLANK on rd_code for any read sampled while in CLEAR.
REQ-030 SHALL, for a read and a put-char write to the same cell in the same cycle, return the pre-write (old) contents; the new value is visible from the next read.
REQ-031 SHALL update cursor outputs on the clock edge that accepts the command.

Reset
REQ-032 SHALL, while reset = 0, force state = CLEAR, clear index = 0, cur_row = 0, cur_col = 0 and rd_code = BLANK asynchronously; consequently wr_ready = 0 and busy = 1.
REQ-033 SHALL, on reset release, run the full clear of REQ-018 before accepting any command, so memory powers up all BLANK.
REQ-034 SHALL, on reset asserted mid-clear or mid-operation, abandon the current activity and restart the full clear from index 0 after release.

Verification
REQ-035 SHALL cover: reset pulse then release -> busy = 1 and wr_ready = 0 for exactly 2400 cycles, then wr_ready = 1, busy = 0, cursor (0,0); a read of every cell returns 3'b000.
REQ-036 SHALL cover: put char codes 1..7 from (0,0) -> cells (0,0)..(0,6) hold 1..7, cursor (0,7); a read of (0,3) gives rd_code = 4 one cycle later.
REQ-037 SHALL cover: 80 put chars then newline at row 29 -> cursor wraps (29,79)->(0,0) on char and newline from (29,5) -> (0,0).
REQ-038 SHALL cover: clear command with wr_valid held high -> one clear accepted, busy for 2400 cycles, following command accepted only after wr_ready returns to 1; all cells BLANK.
REQ-039 SHALL cover: rd_row = 30 or rd_col = 80..127 -> rd_code = 3'b000; a same-cycle read and write of code 5 to (2,2) over old code 3 -> returns 3, then 5 on the next read.
REQ-040 SHALL cover: reset asserted at clear index 1000 -> outputs at reset values immediately, then a full 2400-cycle clear after release.
